// File: rtl/conv_pkg.sv
// Shared types and constants for the convolver window feeder.
package conv_pkg;

  localparam int PIX_W       = 4;
  localparam int TAPS        = 9;
  localparam int SAMPLE_W    = TAPS * PIX_W;
  localparam int RES_W       = 16;
  localparam int TIMEOUT_CYC = 8;
  localparam int TMO_W       = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  // Shift a packed 3x3 window left by one column and insert a new right column.
  // Tap k = 3*row + col; r0 is the oldest row, r2 the current row.
  function automatic logic [SAMPLE_W-1:0] shift_window(
    input logic [SAMPLE_W-1:0] win,
    input logic [PIX_W-1:0]    r0,
    input logic [PIX_W-1:0]    r1,
    input logic [PIX_W-1:0]    r2
  );
    logic [SAMPLE_W-1:0] nxt;
    nxt = win;
    for (int r = 0; r < 3; r++) begin
      nxt[PIX_W*(3*r)   +: PIX_W] = win[PIX_W*(3*r+1) +: PIX_W];
      nxt[PIX_W*(3*r+1) +: PIX_W] = win[PIX_W*(3*r+2) +: PIX_W];
    end
    nxt[PIX_W*2 +: PIX_W] = r0;
    nxt[PIX_W*5 +: PIX_W] = r1;
    nxt[PIX_W*8 +: PIX_W] = r2;
    return nxt;
  endfunction

endpackage

// File: rtl/conv_window_feeder_if.sv
// Pixel stream, multiply/add and result stream signals of the window feeder.
// master: the feeder itself; slave: its environment.
interface conv_window_feeder_if;
  import conv_pkg::*;

  logic [PIX_W-1:0]    pixel_in;
  logic                pixel_valid;
  logic                pixel_ready;
  logic [SAMPLE_W-1:0] sample_out;
  logic                conv_en;
  logic [RES_W-1:0]    result_in;
  logic                result_ready_in;
  logic [RES_W-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic                frame_done;
  logic                timeout_err;

  modport master (
    input  pixel_in, pixel_valid, result_in, result_ready_in, out_ready,
    output pixel_ready, sample_out, conv_en, out_data, out_valid, frame_done, timeout_err
  );

  modport slave (
    output pixel_in, pixel_valid, result_in, result_ready_in, out_ready,
    input  pixel_ready, sample_out, conv_en, out_data, out_valid, frame_done, timeout_err
  );

endinterface

// File: rtl/conv_line_buffer.sv
// Two-row pixel delay line, IMG_W deep. Synchronous write, combinational read
// at the current column. Contents are deliberately not reset.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int COL_W = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [COL_W-1:0] col,
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] old_row,
  output logic [PIX_W-1:0] mid_row
);

  logic [PIX_W-1:0] lb0_r [IMG_W];
  logic [PIX_W-1:0] lb1_r [IMG_W];

  // Push the accepted pixel into row 0 and age row 0 into row 1 at this column.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      lb1_r[col] <= lb0_r[col];
      lb0_r[col] <= pix;
    end
  end

  assign old_row = lb1_r[col];
  assign mid_row = lb0_r[col];

endmodule

// File: rtl/conv_window_feeder.sv
// Convolver window feeder: builds 3x3 windows from a raster pixel stream,
// hands each to the multiply/add block and forwards the 16-bit result.
// Optional macro CONV_FEEDER_TIMEOUT_EN adds a WAIT-state watchdog that drops
// the window after 8 cycles without result_ready_in and sets timeout_err.
module conv_window_feeder
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_feeder_if.master bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  state_e              state_r;
  logic [COL_W-1:0]    col_r;
  logic [ROW_W-1:0]    row_r;
  logic [SAMPLE_W-1:0] win_r;
  logic [RES_W-1:0]    out_data_r;
  logic                out_valid_r;
  logic                conv_en_r;
  logic                pixel_ready_r;
  logic                frame_done_r;

  logic                accept_s;
  logic                col_last_s;
  logic                row_last_s;
  logic                win_done_s;
  logic                tmo_expired_s;
  logic [PIX_W-1:0]    lb_old_s;
  logic [PIX_W-1:0]    lb_mid_s;

  assign accept_s   = bus.pixel_valid & pixel_ready_r;
  assign col_last_s = (col_r == COL_W'(IMG_W - 1));
  assign row_last_s = (row_r == ROW_W'(IMG_H - 1));
  assign win_done_s = (row_r >= ROW_W'(2)) && (col_r >= COL_W'(2));

  conv_line_buffer #(
    .IMG_W (IMG_W),
    .COL_W (COL_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (accept_s),
    .col     (col_r),
    .pix     (bus.pixel_in),
    .old_row (lb_old_s),
    .mid_row (lb_mid_s)
  );

  // Raster position, window shift register and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_r        <= '0;
      row_r        <= '0;
      win_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= accept_s & col_last_s & row_last_s;
      if (accept_s) begin
        win_r <= shift_window(win_r, lb_old_s, lb_mid_s, bus.pixel_in);
        if (col_last_s) begin
          col_r <= '0;
          row_r <= row_last_s ? '0 : row_r + ROW_W'(1);
        end else begin
          col_r <= col_r + COL_W'(1);
        end
      end
    end
  end

`ifdef CONV_FEEDER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             timeout_err_r;

  assign tmo_expired_s = (state_r == WAIT) && !bus.result_ready_in &&
                         (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

  // Count unanswered WAIT cycles; the sticky error is set when the window is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r     <= '0;
      timeout_err_r <= 1'b0;
    end else if (state_r == WAIT && !bus.result_ready_in) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      if (tmo_expired_s) begin
        timeout_err_r <= 1'b1;
      end
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  assign bus.timeout_err = timeout_err_r;
`else
  assign tmo_expired_s   = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  // Window handshake FSM; pixel_ready is registered as "next state is IDLE".
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      pixel_ready_r <= 1'b0;
      conv_en_r     <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= '0;
    end else begin
      conv_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s && win_done_s) begin
            state_r       <= ISSUE;
            conv_en_r     <= 1'b1;
            pixel_ready_r <= 1'b0;
          end else begin
            pixel_ready_r <= 1'b1;
          end
        end
        ISSUE: begin
          state_r <= WAIT;
        end
        WAIT: begin
          if (bus.result_ready_in) begin
            out_data_r  <= bus.result_in;
            out_valid_r <= 1'b1;
            state_r     <= OUTPUT;
          end else if (tmo_expired_s) begin
            state_r       <= IDLE;
            pixel_ready_r <= 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_r   <= 1'b0;
            state_r       <= IDLE;
            pixel_ready_r <= 1'b1;
          end
        end
        default: begin
          state_r       <= IDLE;
          pixel_ready_r <= 1'b1;
          out_valid_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pixel_ready = pixel_ready_r;
  assign bus.sample_out  = win_r;
  assign bus.conv_en     = conv_en_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder with a 4x4 image and a small
// multiply/add responder that answers a configurable number of cycles after conv_en.
module tb_conv_window_feeder;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_feeder_if ifc ();

  conv_window_feeder #(
    .IMG_W (4),
    .IMG_H (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int checks = 0;
  int errors = 0;

  // Responder model: ready pulses model_delay+1 cycles after the conv_en cycle.
  int          model_cnt    = 0;
  int          model_delay  = 0;
  bit          model_on     = 1'b1;
  logic [15:0] model_result = 16'h0000;

  always @(posedge clk) begin
    if (ifc.conv_en === 1'b1 && model_on) model_cnt <= model_delay + 1;
    else if (model_cnt > 0) model_cnt <= model_cnt - 1;
  end
  assign ifc.result_ready_in = (model_cnt == 1);
  assign ifc.result_in       = (model_cnt == 1) ? model_result : 16'hDEAD;

  // Event counters.
  int n_conv = 0;
  int n_out  = 0;
  int n_fd   = 0;
  always @(posedge clk) begin
    if (ifc.conv_en === 1'b1) n_conv <= n_conv + 1;
    if (ifc.out_valid === 1'b1 && ifc.out_ready === 1'b1) n_out <= n_out + 1;
    if (ifc.frame_done === 1'b1) n_fd <= n_fd + 1;
  end

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_pixel(input int n);
    int waited;
    waited = 0;
    ifc.pixel_in    = 4'(n % 16);
    ifc.pixel_valid = 1'b1;
    while (ifc.pixel_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("accept_timeout", 36'(waited), 36'd0);
    @(negedge clk);
    ifc.pixel_valid = 1'b0;
  endtask

  task automatic send_range(input int a, input int b);
    for (int n = a; n <= b; n++) send_pixel(n);
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    while (ifc.pixel_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("idle_timeout", 36'(waited), 36'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pixel_ready"}, 36'(ifc.pixel_ready), 36'd0);
    check({tag, "_conv_en"},     36'(ifc.conv_en),     36'd0);
    check({tag, "_out_valid"},   36'(ifc.out_valid),   36'd0);
    check({tag, "_out_data"},    36'(ifc.out_data),    36'd0);
    check({tag, "_sample_out"},  ifc.sample_out,       36'd0);
    check({tag, "_frame_done"},  36'(ifc.frame_done),  36'd0);
    check({tag, "_timeout_err"}, 36'(ifc.timeout_err), 36'd0);
  endtask

  // Global time limit.
  initial begin
    #300000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int c0, o0, f0;
    ifc.pixel_in    = 4'h0;
    ifc.pixel_valid = 1'b0;
    ifc.out_ready   = 1'b1;

    // Power-on reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    @(negedge clk);
    check("por_pixel_ready_after", 36'(ifc.pixel_ready), 36'd1);

    // Frame 1: nominal latency, window packing, counts.
    model_result = 16'h07E9;
    c0 = n_conv; o0 = n_out; f0 = n_fd;
    send_range(0, 9);
    check("f1_no_early_window", 36'(n_conv - c0), 36'd0);
    send_pixel(10);
    check("f1_conv_en_t1",     36'(ifc.conv_en),     36'd1);
    check("f1_sample_w0",      ifc.sample_out,       36'hA98654210);
    check("f1_pixel_ready_t1", 36'(ifc.pixel_ready), 36'd0);
    @(negedge clk);
    check("f1_conv_en_t2",     36'(ifc.conv_en),     36'd0);
    check("f1_out_valid_t2",   36'(ifc.out_valid),   36'd0);
    check("f1_sample_hold_t2", ifc.sample_out,       36'hA98654210);
    @(negedge clk);
    check("f1_out_valid_t3",   36'(ifc.out_valid),   36'd1);
    check("f1_out_data_t3",    36'(ifc.out_data),    36'h07E9);
    @(negedge clk);
    check("f1_out_valid_t4",   36'(ifc.out_valid),   36'd0);
    check("f1_pixel_ready_t4", 36'(ifc.pixel_ready), 36'd1);
    send_pixel(11);
    check("f1_sample_w1",      ifc.sample_out,       36'hBA9765321);
    send_range(12, 14);
    check("f1_sample_w2",      ifc.sample_out,       36'hEDCA98654);
    send_pixel(15);
    check("f1_frame_done",     36'(ifc.frame_done),  36'd1);
    wait_idle();
    check("f1_conv_count",     36'(n_conv - c0),     36'd4);
    check("f1_out_count",      36'(n_out - o0),      36'd4);
    check("f1_frame_done_cnt", 36'(n_fd - f0),       36'd1);

    // Frame 2: back-pressure on the first result.
    c0 = n_conv; o0 = n_out; f0 = n_fd;
    send_range(0, 9);
    ifc.out_ready = 1'b0;
    model_result  = 16'h1234;
    send_pixel(10);
    repeat (2) @(negedge clk);
    ifc.pixel_in    = 4'hB;
    ifc.pixel_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid",   36'(ifc.out_valid),   36'd1);
      check("bp_out_data",    36'(ifc.out_data),    36'h1234);
      check("bp_pixel_ready", 36'(ifc.pixel_ready), 36'd0);
      @(negedge clk);
    end
    check("bp_no_consume", 36'(n_out - o0), 36'd0);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    check("bp_consumed",       36'(n_out - o0),      36'd1);
    check("bp_out_valid_drop", 36'(ifc.out_valid),   36'd0);
    check("bp_pixel_ready_up", 36'(ifc.pixel_ready), 36'd1);
    send_pixel(11);
    check("bp_sample_w1",      ifc.sample_out,       36'hBA9765321);
    send_range(12, 15);
    wait_idle();
    check("bp_conv_count",     36'(n_conv - c0),     36'd4);
    check("bp_out_count",      36'(n_out - o0),      36'd4);
    check("bp_frame_done_cnt", 36'(n_fd - f0),       36'd1);

    // Frame 3: responder answers three cycles late.
    model_delay  = 3;
    model_result = 16'h0ABC;
    send_range(0, 10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("dly_sample_hold", ifc.sample_out,     36'hA98654210);
      check("dly_out_valid",   36'(ifc.out_valid), 36'd0);
    end
    @(negedge clk);
    check("dly_out_valid_up", 36'(ifc.out_valid), 36'd1);
    check("dly_out_data",     36'(ifc.out_data),  36'h0ABC);
    send_range(11, 15);
    wait_idle();
    model_delay = 0;

    // Reset while a window is in flight (ISSUE), then a clean frame.
    send_range(0, 10);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst1");
    @(negedge clk);
    check_reset_outputs("mid_rst2");
    rst = 1'b0;
    @(negedge clk);
    check("mid_pixel_ready_after", 36'(ifc.pixel_ready), 36'd1);
    check("mid_out_valid_after",   36'(ifc.out_valid),   36'd0);
    model_result = 16'h0042;
    c0 = n_conv; o0 = n_out; f0 = n_fd;
    send_range(0, 9);
    check("mid_no_early_window", 36'(n_conv - c0),    36'd0);
    send_pixel(10);
    check("mid_conv_en",         36'(ifc.conv_en),    36'd1);
    check("mid_sample_w0",       ifc.sample_out,      36'hA98654210);
    repeat (2) @(negedge clk);
    check("mid_out_data",        36'(ifc.out_data),   36'h0042);
    send_range(11, 15);
    wait_idle();
    check("mid_conv_count",      36'(n_conv - c0),    36'd4);
    check("mid_out_count",       36'(n_out - o0),     36'd4);
    check("mid_frame_done_cnt",  36'(n_fd - f0),      36'd1);

`ifdef CONV_FEEDER_TIMEOUT_EN
    // Responder silent: the window is dropped after 8 WAIT cycles.
    model_on = 1'b0;
    o0 = n_out;
    send_range(0, 10);
    check("tmo_conv_en", 36'(ifc.conv_en), 36'd1);
    repeat (8) @(negedge clk);
    check("tmo_still_wait_ready", 36'(ifc.pixel_ready), 36'd0);
    check("tmo_err_not_yet",      36'(ifc.timeout_err), 36'd0);
    @(negedge clk);
    check("tmo_idle_ready", 36'(ifc.pixel_ready), 36'd1);
    check("tmo_err_set",    36'(ifc.timeout_err), 36'd1);
    check("tmo_no_output",  36'(ifc.out_valid),   36'd0);
    send_pixel(11);
    repeat (3) @(negedge clk);
    check("tmo_err_sticky", 36'(ifc.timeout_err), 36'd1);
    check("tmo_out_count",  36'(n_out - o0),      36'd0);
    rst = 1'b1;
    @(negedge clk);
    check("tmo_err_cleared", 36'(ifc.timeout_err), 36'd0);
    rst = 1'b0;
    model_on = 1'b1;
    @(negedge clk);
`else
    check("no_tmo_err", 36'(ifc.timeout_err), 36'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
